ysyx_22050612_core_seq: RTL and testbench

Multi-cycle sequencer for the single-issue NPC core. Drives fetch, decode, execute, memory and writeback in order, and owns the PC and the latched instruction fed to the decoder. Handles ebreak halt, bus-response timeout and misaligned-PC traps. Sits between the instruction/data memory ports and the IDU/EXU/register-file datapath.

---
 rtl/ysyx_22050612_core_seq_if.sv | 24 ++
 rtl/ysyx_22050612_core_seq.sv | 131 +++++++++++++
 tb/tb_ysyx_22050612_core_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050612_core_seq_if.sv
// Instruction and data memory handshake bundle between the core sequencer and
// the memory ports. The core is the master; memories are slaves.
interface ysyx_22050612_core_seq_if;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic        dmem_resp_valid;

   modport master (
      output imem_req_valid, imem_req_addr, dmem_req_valid,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      input  dmem_req_ready, dmem_resp_valid
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, dmem_req_valid,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      output dmem_req_ready, dmem_resp_valid
   );
endinterface

// File: rtl/ysyx_22050612_core_seq.sv
// Multi-cycle IF/DEC/EX/MEM/WB sequencer: owns PC, latched instruction and
// retire count; traps on ebreak, memory response timeout and misaligned PC.
module ysyx_22050612_core_seq #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int          TIMEOUT  = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   ysyx_22050612_core_seq_if.master      bus,
   output logic [31:0]                   inst,
   output logic                          inst_valid,
   input  logic                          is_ebreak,
   input  logic                          is_mem,
   input  logic                          rd_write,
   input  logic [63:0]                   next_pc,
   output logic                          rf_we,
   output logic [63:0]                   pc,
   output logic                          halt,
   output logic                          bus_err,
   output logic [63:0]                   retire_cnt
);

   typedef enum logic [2:0] {
      S_IF_REQ, S_IF_WAIT, S_DEC, S_EX, S_MEM_REQ, S_MEM_WAIT, S_WB, S_HALT
   } state_t;

   // Counter holds the number of wait cycles already spent, so the last
   // permitted wait cycle is the one where it equals TIMEOUT-1.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      r_state, w_next;
   logic [63:0] r_pc, r_npc, r_retire;
   logic [31:0] r_inst;
   logic        r_bus_err;
   logic [15:0] r_tcnt;
   logic        w_set_err, w_tclr, w_tmo;
   logic        w_imem_req_valid, w_dmem_req_valid, w_inst_valid, w_rf_we;

   assign w_tmo = (r_tcnt == TMO_LAST);

   always_comb begin
      w_next           = r_state;
      w_set_err        = 1'b0;
      w_tclr           = 1'b0;
      w_imem_req_valid = 1'b0;
      w_dmem_req_valid = 1'b0;
      w_inst_valid     = 1'b0;
      w_rf_we          = 1'b0;
      case (r_state)
         S_IF_REQ: begin
            w_imem_req_valid = 1'b1;
            if (bus.imem_req_ready) begin
               w_next = S_IF_WAIT;
               w_tclr = 1'b1;
            end
         end
         S_IF_WAIT: begin
            if (bus.imem_resp_valid) w_next = S_DEC;
            else if (w_tmo) begin
               w_next    = S_HALT;
               w_set_err = 1'b1;
            end
         end
         S_DEC: begin
            w_inst_valid = 1'b1;
            w_next       = is_ebreak ? S_HALT : S_EX;
         end
         S_EX: begin
            if (next_pc[1:0] != 2'b00) begin
               w_next    = S_HALT;
               w_set_err = 1'b1;
            end else if (is_mem) w_next = S_MEM_REQ;
            else                 w_next = S_WB;
         end
         S_MEM_REQ: begin
            w_dmem_req_valid = 1'b1;
            if (bus.dmem_req_ready) begin
               w_next = S_MEM_WAIT;
               w_tclr = 1'b1;
            end
         end
         S_MEM_WAIT: begin
            if (bus.dmem_resp_valid) w_next = S_WB;
            else if (w_tmo) begin
               w_next    = S_HALT;
               w_set_err = 1'b1;
            end
         end
         S_WB: begin
            w_rf_we = rd_write;
            w_next  = S_IF_REQ;
         end
         default: w_next = S_HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IF_REQ;
         r_pc      <= RESET_PC;
         r_npc     <= 64'd0;
         r_inst    <= 32'd0;
         r_retire  <= 64'd0;
         r_bus_err <= 1'b0;
         r_tcnt    <= 16'd0;
      end else begin
         r_state <= w_next;
         if (w_set_err) r_bus_err <= 1'b1;
         if (w_tclr) r_tcnt <= 16'd0;
         else if (r_state == S_IF_WAIT || r_state == S_MEM_WAIT) r_tcnt <= r_tcnt + 16'd1;
         if (r_state == S_IF_WAIT && bus.imem_resp_valid) r_inst <= bus.imem_resp_data;
         if (r_state == S_EX) r_npc <= next_pc;
         if (r_state == S_WB) begin
            r_pc     <= r_npc;
            r_retire <= r_retire + 64'd1;
         end
      end
   end

   assign bus.imem_req_valid = w_imem_req_valid;
   assign bus.imem_req_addr  = r_pc;
   assign bus.dmem_req_valid = w_dmem_req_valid;
   assign inst               = r_inst;
   assign inst_valid         = w_inst_valid;
   assign rf_we              = w_rf_we;
   assign pc                 = r_pc;
   assign halt               = (r_state == S_HALT);
   assign bus_err            = r_bus_err;
   assign retire_cnt         = r_retire;

endmodule

// File: tb/tb_ysyx_22050612_core_seq.sv
// Directed bench for the core sequencer: fetch/decode/execute/memory/writeback
// flow, stalls, ebreak halt, timeout and misaligned-PC traps, async reset.
module tb_ysyx_22050612_core_seq;
   localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;
   localparam logic [31:0] ADDI  = 32'h0010_0093;
   localparam logic [31:0] LW    = 32'h0000_a103;
   localparam logic [31:0] EBRK  = 32'h0010_0073;

   logic clk = 1'b0, rst = 1'b1;
   logic is_ebreak, is_mem, rd_write;
   logic [63:0] next_pc;
   logic [31:0] inst, inst4;
   logic inst_valid, rf_we, halt, bus_err;
   logic inst_valid4, rf_we4, halt4, bus_err4;
   logic [63:0] pc, retire_cnt, pc4, retire_cnt4;
   int checks = 0, errors = 0;

   ysyx_22050612_core_seq_if bus ();
   ysyx_22050612_core_seq_if bus4 ();

   assign bus4.imem_req_ready  = bus.imem_req_ready;
   assign bus4.imem_resp_valid = bus.imem_resp_valid;
   assign bus4.imem_resp_data  = bus.imem_resp_data;
   assign bus4.dmem_req_ready  = bus.dmem_req_ready;
   assign bus4.dmem_resp_valid = bus.dmem_resp_valid;

   ysyx_22050612_core_seq #(.RESET_PC(RPC), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .bus(bus), .inst(inst), .inst_valid(inst_valid),
      .is_ebreak(is_ebreak), .is_mem(is_mem), .rd_write(rd_write), .next_pc(next_pc),
      .rf_we(rf_we), .pc(pc), .halt(halt), .bus_err(bus_err), .retire_cnt(retire_cnt));

   ysyx_22050612_core_seq #(.RESET_PC(RPC), .TIMEOUT(4)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4), .inst(inst4), .inst_valid(inst_valid4),
      .is_ebreak(is_ebreak), .is_mem(is_mem), .rd_write(rd_write), .next_pc(next_pc),
      .rf_we(rf_we4), .pc(pc4), .halt(halt4), .bus_err(bus_err4), .retire_cnt(retire_cnt4));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = 32'd0;
      bus.dmem_req_ready = 1'b0; bus.dmem_resp_valid = 1'b0;
      is_ebreak = 1'b0; is_mem = 1'b0; rd_write = 1'b0; next_pc = 64'd0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (pc !== RPC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RPC); end
      checks++; if (inst !== 32'd0) begin errors++; $display("FAIL reset_inst: got %h want 0", inst); end
      checks++; if ({halt, bus_err, inst_valid, rf_we, bus.dmem_req_valid} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {halt, bus_err, inst_valid, rf_we, bus.dmem_req_valid}); end
      checks++; if (retire_cnt !== 64'd0) begin errors++; $display("FAIL reset_retire: got %0d want 0", retire_cnt); end
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RPC) begin errors++; $display("FAIL reset_ifreq: got v=%b a=%h want v=1 a=%h", bus.imem_req_valid, bus.imem_req_addr, RPC); end
   endtask

   task automatic test_addi();
      do_reset();
      bus.imem_req_ready = 1'b1; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = ADDI;
      rd_write = 1'b1; next_pc = RPC + 64'd4;
      step();
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL addi_ifwait_req: got %b want 0", bus.imem_req_valid); end
      step();
      checks++; if (inst_valid !== 1'b1 || inst !== ADDI) begin errors++; $display("FAIL addi_dec: got v=%b inst=%h want v=1 inst=%h", inst_valid, inst, ADDI); end
      step();
      checks++; if (inst_valid !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL addi_ex: got iv=%b we=%b want 0 0", inst_valid, rf_we); end
      step();
      checks++; if (rf_we !== 1'b1 || pc !== RPC) begin errors++; $display("FAIL addi_wb: got we=%b pc=%h want we=1 pc=%h", rf_we, pc, RPC); end
      step();
      checks++; if (rf_we !== 1'b0 || pc !== 64'h8000_0004 || retire_cnt !== 64'd1 || bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL addi_retire: got we=%b pc=%h rc=%0d req=%b want 0 80000004 1 1", rf_we, pc, retire_cnt, bus.imem_req_valid); end
   endtask

   task automatic test_imem_stall();
      do_reset();
      bus.imem_resp_valid = 1'b1; bus.imem_resp_data = ADDI; rd_write = 1'b0; next_pc = RPC + 64'd4;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RPC) begin errors++; $display("FAIL stall_hold%0d: got v=%b a=%h want v=1 a=%h", i, bus.imem_req_valid, bus.imem_req_addr, RPC); end
      end
      bus.imem_req_ready = 1'b1;
      step(); step();
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stall_dec: got %b want 1", inst_valid); end
      step(); step();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL stall_wb_nowrite: got %b want 0", rf_we); end
      step();
      checks++; if (retire_cnt !== 64'd1 || pc !== 64'h8000_0004) begin errors++; $display("FAIL stall_retire: got rc=%0d pc=%h want 1 80000004", retire_cnt, pc); end
   endtask

   task automatic test_mem_load();
      int ncyc;
      do_reset();
      bus.imem_req_ready = 1'b1; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = LW;
      is_mem = 1'b1; rd_write = 1'b1; next_pc = RPC + 64'd4;
      for (int i = 0; i < 4; i++) step();
      ncyc = 4;
      checks++; if (bus.dmem_req_valid !== 1'b1) begin errors++; $display("FAIL mem_req: got %b want 1", bus.dmem_req_valid); end
      bus.dmem_resp_valid = 1'b1;
      step(); ncyc++;
      checks++; if (bus.dmem_req_valid !== 1'b1) begin errors++; $display("FAIL mem_req_hold: got %b want 1", bus.dmem_req_valid); end
      bus.dmem_req_ready = 1'b1;
      step(); ncyc++;
      bus.dmem_resp_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.dmem_req_valid !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL mem_wait%0d: got req=%b we=%b want 0 0", i, bus.dmem_req_valid, rf_we); end
         step(); ncyc++;
      end
      bus.dmem_resp_valid = 1'b1;
      step(); ncyc++;
      checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL mem_wb: got %b want 1", rf_we); end
      step(); ncyc++;
      checks++; if (retire_cnt !== 64'd1 || pc !== 64'h8000_0004 || ncyc != 12) begin errors++; $display("FAIL mem_retire: got rc=%0d pc=%h cyc=%0d want 1 80000004 12", retire_cnt, pc, ncyc); end
   endtask

   task automatic test_ebreak();
      do_reset();
      bus.imem_req_ready = 1'b1; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = EBRK;
      is_ebreak = 1'b1; next_pc = RPC + 64'd4;
      step(); step();
      checks++; if (inst !== EBRK) begin errors++; $display("FAIL ebreak_inst: got %h want %h", inst, EBRK); end
      step();
      checks++; if (halt !== 1'b1 || bus_err !== 1'b0 || retire_cnt !== 64'd0) begin errors++; $display("FAIL ebreak_halt: got h=%b e=%b rc=%0d want 1 0 0", halt, bus_err, retire_cnt); end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (bus.imem_req_valid !== 1'b0 || halt !== 1'b1 || pc !== RPC) begin errors++; $display("FAIL ebreak_hold%0d: got req=%b h=%b pc=%h want 0 1 %h", i, bus.imem_req_valid, halt, pc, RPC); end
      end
      is_ebreak = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      bus.imem_req_ready = 1'b1;
      step(); step(); step(); step();
      checks++; if (halt4 !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", halt4); end
      step();
      checks++; if (halt4 !== 1'b1 || bus_err4 !== 1'b1) begin errors++; $display("FAIL tmo_trap: got h=%b e=%b want 1 1", halt4, bus_err4); end
      bus.imem_resp_valid = 1'b1; bus.imem_resp_data = ADDI;
      step(); step();
      checks++; if (halt4 !== 1'b1 || inst4 !== 32'd0 || bus4.imem_req_valid !== 1'b0) begin errors++; $display("FAIL tmo_hold: got h=%b inst=%h req=%b want 1 0 0", halt4, inst4, bus4.imem_req_valid); end
      do_reset();
      bus.imem_req_ready = 1'b1; bus.imem_resp_data = ADDI;
      step(); step(); step(); step();
      bus.imem_resp_valid = 1'b1;
      step();
      checks++; if (inst_valid4 !== 1'b1 || halt4 !== 1'b0 || bus_err4 !== 1'b0 || inst4 !== ADDI) begin errors++; $display("FAIL tmo_edge_resp: got iv=%b h=%b e=%b inst=%h want 1 0 0 %h", inst_valid4, halt4, bus_err4, inst4, ADDI); end
   endtask

   task automatic test_misaligned_and_reset();
      do_reset();
      bus.imem_req_ready = 1'b1; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = ADDI;
      rd_write = 1'b1; next_pc = 64'h8000_0002;
      for (int i = 0; i < 4; i++) step();
      checks++; if (halt !== 1'b1 || bus_err !== 1'b1 || pc !== RPC || retire_cnt !== 64'd0) begin errors++; $display("FAIL misalign: got h=%b e=%b pc=%h rc=%0d want 1 1 %h 0", halt, bus_err, pc, retire_cnt, RPC); end
      do_reset();
      bus.imem_req_ready = 1'b1; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = LW;
      bus.dmem_req_ready = 1'b1; is_mem = 1'b1; rd_write = 1'b1; next_pc = RPC + 64'd4;
      for (int i = 0; i < 6; i++) step();
      bus.dmem_resp_valid = 1'b1;
      rst = 1'b1;
      #1;
      checks++; if (pc !== RPC || bus.imem_req_valid !== 1'b1 || bus.dmem_req_valid !== 1'b0) begin errors++; $display("FAIL async_rst: got pc=%h ireq=%b dreq=%b want %h 1 0", pc, bus.imem_req_valid, bus.dmem_req_valid, RPC); end
      step();
      rst = 1'b0;
      bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      checks++; if (bus.imem_req_valid !== 1'b1 || rf_we !== 1'b0 || retire_cnt !== 64'd0 || halt !== 1'b0) begin errors++; $display("FAIL rst_stale: got ireq=%b we=%b rc=%0d h=%b want 1 0 0 0", bus.imem_req_valid, rf_we, retire_cnt, halt); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_imem_stall();
      test_mem_load();
      test_ebreak();
      test_timeout();
      test_misaligned_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
